// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StTrap,
    StRet
  } trap_state_e;

  localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_target_calc.sv
// Handler address from mtvec and the trap cause; reserved modes behave as direct.
module trap_target_calc
  import trap_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] cause_i,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] code;

  always_comb begin
    base = {mtvec_i[XLEN-1:2], 2'b00};
    code = {1'b0, cause_i[XLEN-2:0]};
    unique case (mtvec_i[1:0])
      MTVEC_DIRECT:   target_o = base;
      // Only interrupts are vectored; synchronous exceptions land on base.
      MTVEC_VECTORED: target_o = cause_i[XLEN-1] ? base + (code << 2) : base;
      default:        target_o = base;
    endcase
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/exit sequencer: qualifies the timer interrupt, drains the pipe,
// then issues one-cycle CSR update + fetch redirect for interrupt, ecall and mret.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN          = 64,
  parameter logic [XLEN-1:0] RESET_PC      = XLEN'(64'h8000_0000),
  parameter int unsigned     DRAIN_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_mstatus_mie,
  input  logic            i_mstatus_mpie,
  input  logic            i_mie_mtie,
  input  logic            i_clint_mtip,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_wb_valid,
  input  logic [XLEN-1:0] i_wb_pc,
  input  logic [XLEN-1:0] i_wb_npc,
  input  logic            i_wb_ecall,
  input  logic            i_wb_mret,
  input  logic            i_pipe_empty,
  output logic            o_stall_fetch,
  output logic            o_flush,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_csr_we,
  output logic [XLEN-1:0] o_mepc_wdata,
  output logic [XLEN-1:0] o_mcause_wdata,
  output logic            o_mie_wdata,
  output logic            o_mpie_wdata,
  output logic            o_intr_taken,
  output logic            o_drain_err
);

  localparam int unsigned     CntW       = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax     = CntW'(DRAIN_TIMEOUT);
  localparam logic [XLEN-1:0] CauseMti   = {1'b1, (XLEN-1)'(CAUSE_MTI[62:0])};
  localparam logic [XLEN-1:0] CauseEcall = XLEN'(CAUSE_ECALL_M);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] last_npc_q;
  logic [XLEN-1:0] mepc_q, mepc_d, cause_q, cause_d, target_q, target_d;
  logic            mie_w_q, mie_w_d, mpie_w_q, mpie_w_d, intr_q, intr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            irq, ecall, mret, active;
  logic [XLEN-1:0] tgt_cause, tgt_pc;

  assign irq       = i_mstatus_mie & i_mie_mtie & i_clint_mtip;
  assign ecall     = i_wb_valid & i_wb_ecall;
  assign mret      = i_wb_valid & i_wb_mret;
  assign tgt_cause = ecall ? CauseEcall : CauseMti;

  trap_target_calc #(
    .XLEN(XLEN)
  ) u_target (
    .mtvec_i (i_mtvec),
    .cause_i (tgt_cause),
    .target_o(tgt_pc)
  );

  always_comb begin
    state_d  = state_q;
    mepc_d   = mepc_q;
    cause_d  = cause_q;
    target_d = target_q;
    mie_w_d  = mie_w_q;
    mpie_w_d = mpie_w_q;
    intr_d   = intr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle, StDrain: begin
        if (ecall) begin
          state_d  = StTrap;
          mepc_d   = i_wb_pc;
          cause_d  = CauseEcall;
          target_d = tgt_pc;
          mie_w_d  = 1'b0;
          mpie_w_d = i_mstatus_mie;
          intr_d   = 1'b0;
        end else if (mret) begin
          // mcause is left as last written; mepc is re-written with its own value.
          state_d  = StRet;
          mepc_d   = i_mepc;
          target_d = i_mepc;
          mie_w_d  = i_mstatus_mpie;
          mpie_w_d = 1'b1;
          intr_d   = 1'b0;
        end else if (state_q == StIdle) begin
          if (irq) begin
            state_d = StDrain;
            cnt_d   = '0;
          end
        end else if (!irq) begin
          state_d = StIdle;
        end else if (i_pipe_empty) begin
          state_d  = StTrap;
          mepc_d   = last_npc_q;
          cause_d  = CauseMti;
          target_d = tgt_pc;
          mie_w_d  = 1'b0;
          mpie_w_d = i_mstatus_mie;
          intr_d   = 1'b1;
        end
        if (state_q == StDrain) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntMax) err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_npc_q <= RESET_PC;
      mepc_q     <= '0;
      cause_q    <= '0;
      target_q   <= '0;
      mie_w_q    <= 1'b0;
      mpie_w_q   <= 1'b0;
      intr_q     <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (i_wb_valid) last_npc_q <= i_wb_npc;
      mepc_q     <= mepc_d;
      cause_q    <= cause_d;
      target_q   <= target_d;
      mie_w_q    <= mie_w_d;
      mpie_w_q   <= mpie_w_d;
      intr_q     <= intr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign active           = (state_q == StTrap) || (state_q == StRet);
  assign o_stall_fetch    = (state_q == StDrain);
  assign o_csr_we         = active;
  assign o_flush          = active;
  assign o_redirect_valid = active;
  assign o_redirect_pc    = active ? target_q : '0;
  assign o_mepc_wdata     = active ? mepc_q : '0;
  assign o_mcause_wdata   = active ? cause_q : '0;
  assign o_mie_wdata      = active & mie_w_q;
  assign o_mpie_wdata     = active & mpie_w_q;
  assign o_intr_taken     = (state_q == StTrap) & intr_q;
  assign o_drain_err      = err_q;

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Machine-mode trap entry/exit sequencer between the CSR file, the CLINT timer and the IF/WB pipeline stages. It qualifies the timer interrupt with mstatus.MIE and mie.MTIE, and drains the pipeline before taking an interrupt. It then performs the mepc/mcause/mstatus updates and redirects fetch to the mtvec-derived handler address. It also sequences ecall entry and mret exit.

## Interface
- XLEN, 64, datapath/CSR width
- RESET_PC, 64'h8000_0000, reset value of the tracked next-PC
- DRAIN_TIMEOUT, 64, DRAIN cycles before o_drain_err sets
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- i_mstatus_mie  input  1  current mstatus.MIE
- i_mstatus_mpie  input  1  current mstatus.MPIE
- i_mie_mtie  input  1  current mie.MTIE
- i_clint_mtip  input  1  CLINT timer-pending level
- i_mtvec  input  XLEN  mtvec CSR
- i_mepc  input  XLEN  mepc CSR (mret target)
- i_wb_valid  input  1  instruction commits this cycle
- i_wb_pc / i_wb_npc  input  XLEN  committing PC / its successor PC
- i_wb_ecall, i_wb_mret  input  1  committing instruction is ecall / mret (qualified by i_wb_valid)
- i_pipe_empty  input  1  no valid instruction in ID/EX/MEM/WB
- o_stall_fetch  output  1  IF must not issue new instructions
- o_flush  output  1  kill all in-flight instructions
- o_redirect_valid  output  1  load o_redirect_pc into IF PC
- o_redirect_pc  output  XLEN  redirect target
- o_csr_we  output  1  write o_mepc_wdata, o_mcause_wdata, o_mie_wdata, o_mpie_wdata
- o_mepc_wdata / o_mcause_wdata  output  XLEN  values for mepc / mcause
- o_mie_wdata / o_mpie_wdata  output  1  new mstatus.MIE / MPIE
- o_intr_taken  output  1  one-cycle pulse on interrupt entry, drives the simulation DPI hook
- o_drain_err  output  1  sticky drain-timeout flag

## Operation
- Interrupt request: irq = i_mstatus_mie & i_mie_mtie & i_clint_mtip. Sampled only in IDLE and DRAIN.
- States: IDLE, DRAIN, TRAP, RET.
- IDLE: committing ecall -> TRAP (cause 11, mepc=i_wb_pc). Else committing mret -> RET. Else irq -> DRAIN. Priority is ecall > mret > irq.
- DRAIN: o_stall_fetch=1. Committing ecall -> TRAP (cause 11). Committing mret -> RET. irq drops, e.g. MIE cleared by a committed csrrw -> IDLE with no trap. i_pipe_empty -> TRAP (interrupt, cause 64'h8000_0000_0000_0007, mepc=last_npc).
- last_npc register: loads i_wb_npc on every i_wb_valid. Resets to RESET_PC.
- TRAP, one cycle: o_csr_we=1, o_flush=1, o_redirect_valid=1, o_mie_wdata=0, o_mpie_wdata=MIE value latched at trap decision. o_intr_taken=1 for interrupt cause only. -> IDLE.
- Target: mtvec[1:0]==0 gives {mtvec[XLEN-1:2],2'b0}. mtvec[1:0]==1 with interrupt gives base + (cause_code<<2), i.e. base+0x1C for timer. mtvec[1:0]==1 with ecall gives base. Sum is modulo 2^XLEN.
- RET, one cycle: o_csr_we=1, o_flush=1, o_redirect_valid=1, o_redirect_pc=i_mepc, o_mie_wdata=i_mstatus_mpie, o_mpie_wdata=1. mepc/mcause write-data = current values (no change). -> IDLE.
- Drain counter: cleared on DRAIN entry, increments each DRAIN cycle, saturates. Reaching DRAIN_TIMEOUT sets o_drain_err, cleared only by rst. The sequencer keeps waiting.

## Timing
- Reset: state=IDLE; all outputs 0; o_redirect_pc/o_mepc_wdata/o_mcause_wdata=0; last_npc=RESET_PC.
- All outputs decode from registered state and latched trap data; no input-to-output combinational path except o_stall_fetch, which is state-only.
- irq at cycle N in IDLE: DRAIN at N+1, stall visible at N+1. i_pipe_empty at cycle M: TRAP at M+1, IDLE at M+2.
- Ecall/mret committing at N: TRAP/RET at N+1; minimum trap latency is 1 cycle.
- Trap data (cause, mepc, target, old MIE) is latched on the decision edge. Input changes during TRAP/RET are ignored.
- After TRAP MIE=0, so a still-pending mtip cannot re-enter until mret. Back-to-back entry is impossible.
- Async rst mid-DRAIN/TRAP aborts without a CSR write.

## Structure
- Shared package trap_pkg holds: state enum, CAUSE_MTI (64'h8000_0000_0000_0007), CAUSE_ECALL_M (64'd11), MTVEC_DIRECT/MTVEC_VECTORED encodings.
- Optional sub-module trap_target_calc, combinational: mtvec, cause -> handler PC.

## Test plan
- MIE=1, MTIE=1, mtip rises with 3 instrs in flight, i_pipe_empty after 4 cycles, last i_wb_npc=0x8000_0010. Expect: stall for 4 cycles; TRAP pulse with mepc=0x8000_0010, mcause=0x8000…0007, MIE→0, MPIE→1, redirect=mtvec.
- mtvec=0x8000_1001 (vectored), timer trap. Expect redirect 0x8000_101C. Ecall at pc 0x8000_0040. Expect redirect 0x8000_1000, mepc=0x8000_0040, mcause=11.
- Ecall commits in IDLE while mtip=1. Expect ecall TRAP first (cause 11); no interrupt entry until mret restores MIE=1, then DRAIN→TRAP.
- In DRAIN, a commit clears MIE (irq→0). Expect IDLE, stall released, no CSR write, no o_intr_taken.
- mret with MPIE=1, mepc=0x8000_0020. Expect RET: redirect 0x8000_0020, MIE→1, MPIE→1, flush.
- i_pipe_empty held 0 for DRAIN_TIMEOUT cycles. Expect o_drain_err=1, sticky; rst asserted mid-DRAIN returns to IDLE with all outputs 0.
